fp_round_unit: RTL

Floating-point rounding and exception stage for the MicroGT-01 FPU. It sits directly downstream of the FP multiply unit and the other FP arithmetic units. It takes an unrounded single-precision result with guard/round/sticky bits and the producer's exception flags, and applies the RISC-V rounding mode. It emits the final IEEE-754 binary32 word plus the `fflags` accrual vector to the writeback/commit stage over a valid/ack handshake.

---
 rtl/fp_round_unit_if.sv | 31 +++
 rtl/fp_round_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fp_round_unit_if.sv
// Shared types and the producer/consumer bus of the FP rounding stage.
package fp_round_pkg;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

interface fp_round_if;
  import fp_round_pkg::*;
  logic        valid_i;
  logic [31:0] operand_i;
  logic [2:0]  grs_i;
  logic [2:0]  round_mode_i;
  logic        overflow_i;
  logic        underflow_i;
  logic        invalid_op_i;
  logic        ack_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic        valid_o;
  fu_state_e   fu_state_o;

  modport master (
    output valid_i, operand_i, grs_i, round_mode_i, overflow_i, underflow_i,
           invalid_op_i, ack_i,
    input  result_o, fflags_o, valid_o, fu_state_o
  );
  modport slave (
    input  valid_i, operand_i, grs_i, round_mode_i, overflow_i, underflow_i,
           invalid_op_i, ack_i,
    output result_o, fflags_o, valid_o, fu_state_o
  );
endinterface

// File: rtl/fp_round_unit.sv
// Binary32 rounding/exception stage: applies the RISC-V rounding mode to an
// unrounded result with G/R/S bits and returns the final word plus fflags.
module fp_round_unit
  import fp_round_pkg::*;
#(
  parameter int BIAS = 127
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clk_en_i,
  fp_round_if.slave bus
);
  localparam logic [7:0] EXP_MAX = 8'(2 * BIAS + 1);

  typedef enum logic [1:0] {IDLE, ROUND, NORMALIZE, VALID} state_e;

  state_e      state, nxt;
  logic [31:0] op_q, res_q;
  logic [2:0]  grs_q, mode_q;
  logic        of_q, uf_q, inv_q;
  logic [4:0]  flg_q;

  logic        sgn, inexact, inc, carry;
  logic [7:0]  ex, ex_inc;
  logic [22:0] man;
  logic [23:0] man_sum;
  logic [31:0] ovf_res, rnd_res, norm_res;
  logic [4:0]  rnd_flg, norm_flg;

  always_comb begin
    sgn     = op_q[31];
    ex      = op_q[30:23];
    man     = op_q[22:0];
    inexact = |grs_q;
    ex_inc  = ex + 8'd1;
    case (mode_q)
      3'd0:    inc = grs_q[2] & (grs_q[1] | grs_q[0] | man[0]);
      3'd2:    inc = sgn & inexact;
      3'd3:    inc = ~sgn & inexact;
      3'd4:    inc = grs_q[2];
      default: inc = 1'b0;
    endcase
    // hidden bit is 1 on the normal path, so a carry past the mantissa
    // is exactly the 24-bit significand overflowing
    man_sum = {1'b0, man} + 24'(inc);
    case (mode_q)
      3'd1:    ovf_res = {sgn, 31'h7F7F_FFFF};
      3'd2:    ovf_res = sgn ? 32'hFF80_0000 : 32'h7F7F_FFFF;
      3'd3:    ovf_res = sgn ? 32'hFF7F_FFFF : 32'h7F80_0000;
      default: ovf_res = {sgn, 31'h7F80_0000};
    endcase

    carry   = 1'b0;
    rnd_res = {sgn, ex, man_sum[22:0]};
    rnd_flg = {4'b0, inexact};
    if (inv_q || mode_q > 3'd4) begin
      rnd_res = 32'h7FC0_0000;
      rnd_flg = 5'h10;
    end else if (ex == EXP_MAX && man != 23'd0) begin
      rnd_res = 32'h7FC0_0000;
      rnd_flg = {~man[22], 4'b0};
    end else if (of_q) begin
      rnd_res = ovf_res;
      rnd_flg = 5'h05;
    end else if (uf_q) begin
      rnd_res = {sgn, 31'b0};
      rnd_flg = 5'h03;
    end else if (ex == EXP_MAX) begin
      rnd_res = op_q;
      rnd_flg = 5'h00;
    end else if (ex == 8'd0) begin
      rnd_res = {sgn, 31'b0};
    end else begin
      carry = man_sum[23];
    end

    if (ex_inc == EXP_MAX) begin
      norm_res = ovf_res;
      norm_flg = 5'h05;
    end else begin
      norm_res = {sgn, ex_inc, 23'b0};
      norm_flg = {4'b0, inexact};
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (bus.valid_i) nxt = ROUND;
      ROUND:     nxt = carry ? NORMALIZE : VALID;
      NORMALIZE: nxt = VALID;
      VALID:     if (bus.ack_i && bus.valid_o) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         state <= IDLE;
    else if (clk_en_i) state <= nxt;
  end

  assign bus.fu_state_o = (state == IDLE) ? FREE : BUSY;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q         <= '0;
      grs_q        <= '0;
      mode_q       <= '0;
      of_q         <= 1'b0;
      uf_q         <= 1'b0;
      inv_q        <= 1'b0;
      res_q        <= '0;
      flg_q        <= '0;
      bus.result_o <= '0;
      bus.fflags_o <= '0;
      bus.valid_o  <= 1'b0;
    end else if (clk_en_i) begin
      case (state)
        IDLE: if (bus.valid_i) begin
          op_q   <= bus.operand_i;
          grs_q  <= bus.grs_i;
          mode_q <= bus.round_mode_i;
          of_q   <= bus.overflow_i;
          uf_q   <= bus.underflow_i;
          inv_q  <= bus.invalid_op_i;
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flg;
        end
        NORMALIZE: begin
          res_q <= norm_res;
          flg_q <= norm_flg;
        end
        VALID: begin
          // first VALID cycle loads the output register, ack only counts after
          if (!bus.valid_o) begin
            bus.result_o <= res_q;
            bus.fflags_o <= flg_q;
            bus.valid_o  <= 1'b1;
          end else if (bus.ack_i) begin
            bus.valid_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
